// File: rtl/mem_dump_pkg.sv
// Shared types for the spram8 dump/load masters.
// Holds the dump FSM encoding, read latency and checksum helper.
package mem_dump_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } dump_st_t;

    localparam int RD_LAT = 1;

    function automatic logic [7:0] csum_add(
        input logic [7:0] acc,
        input logic [7:0] b
    );
        return acc + b;
    endfunction

endpackage

// File: rtl/dump_fifo2.sv
// Two-entry byte FIFO between the mb8 read port and the tx stream.
// Accepts a push while full only when a pop happens in the same cycle.
module dump_fifo2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] din,
    output logic       full,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       empty,
    output logic [1:0] count
);

    logic [7:0] d0, d1;
    logic       wp, rp;
    logic       do_push, do_pop;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = rp ? d1 : d0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d0    <= '0;
            d1    <= '0;
            wp    <= 1'b0;
            rp    <= 1'b0;
            count <= '0;
        end else begin
            if (do_push) begin
                if (wp) d1 <= din;
                else    d0 <= din;
                wp <= ~wp;
            end
            if (do_pop)
                rp <= ~rp;
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_dump.sv
// Streams a byte range of spram8 over mb8 onto a valid/ready byte stream,
// with an 8-bit running checksum of the accepted bytes.
module mem_dump
    import mem_dump_pkg::*;
#(
    parameter int ASZ  = 17,
    parameter int LENW = 17
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [ASZ-1:0]  base,
    input  logic [LENW-1:0] len,
    input  logic            abort,
    output logic            busy,
    output logic            done,
    output logic [7:0]      csum,
    output logic [ASZ-1:0]  mem_addr,
    output logic            mem_we,
    input  logic [7:0]      mem_vo,
    output logic [7:0]      tx_data,
    output logic            tx_valid,
    input  logic            tx_ready
);

    dump_st_t        state, state_nx;
    logic [ASZ-1:0]  cur;
    logic [LENW-1:0] rem;
    logic            inflight;
    logic            fifo_full, fifo_empty;
    logic [1:0]      fifo_cnt;
    logic            pop, issue, go;
    logic [2:0]      occ;

    assign mem_we   = 1'b0;
    assign tx_valid = !fifo_empty;
    assign pop      = tx_valid && tx_ready;
    assign go       = (state == IDLE) && start;

    // Occupancy after this cycle's pop, so a read can overlap a drain.
    assign occ = 3'(fifo_cnt) + 3'(inflight) - 3'(pop);

    assign issue = (state == READ) && !abort && (rem != '0)
                 && (occ < 3'd2) && (!fifo_full || pop);

    dump_fifo2 u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (inflight),
        .din   (mem_vo),
        .full  (fifo_full),
        .pop   (pop),
        .dout  (tx_data),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:
                if (start)
                    state_nx = (len == '0) ? DONE : READ;
            READ:
                if (abort || (issue && rem == LENW'(1)))
                    state_nx = DRAIN;
            DRAIN:
                if (fifo_empty && !inflight)
                    state_nx = DONE;
            DONE:
                state_nx = IDLE;
            default:
                state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cur      <= '0;
            rem      <= '0;
            inflight <= 1'b0;
            mem_addr <= '0;
            csum     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nx;
            inflight <= issue;
            done     <= (state == DONE);
            if (go) begin
                cur  <= base;
                rem  <= len;
                csum <= '0;
                busy <= 1'b1;
            end else if (pop) begin
                csum <= csum_add(csum, tx_data);
            end
            if (state == DONE)
                busy <= 1'b0;
            if (issue) begin
                mem_addr <= cur;
                cur      <= cur + ASZ'(1);
                rem      <= rem - LENW'(1);
            end
        end
    end

endmodule
